window_gen_3x3: RTL and testbench
=================================

WINDOW_GEN_3X3 -- requirements
Module: window_gen_3x3

Interface
REQ-001 Parameter WL, 96, word width of one padded pixel word.
REQ-002 Parameter COLS, 17, padded frame width in words.
REQ-003 Parameter ROWS, 14, padded frame height in words.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 sof  input  1  start-of-frame strobe; restarts the frame position.
REQ-007 in_valid  input  1  in carries a padded-stream word this cycle.
REQ-008 in  input  WL  padded pixel word, raster order, row-major.
REQ-009 win_valid  output  1  win, out_row and out_col hold a new 3x3 window this cycle.
REQ-010 win  output  9*WL  window; element (r,c) at bits [WL*(3r+c) +: WL]; r=0 is top row, c=0 is left column.
REQ-011 out_row  output  4  unpadded row index of the window centre, 0..ROWS-3.
REQ-012 out_col  output  4  unpadded column index of the window centre, 0..COLS-3.
REQ-013 frame_done  output  1  one-cycle pulse coincident with the last window of a frame.
REQ-014 busy  output  1  high while a frame is in progress (state not IDLE).

Function
REQ-015 Each accepted word (in_valid=1) has a padded position (R,C): C in 0..COLS-1, R in 0..ROWS-1; C increments per accepted word; at C=COLS-1, C wraps to 0 and R increments.
REQ-016 With in_valid=0, no counter, buffer or state changes; win_valid=0.
REQ-017 Two line buffers of COLS x WL words each hold padded rows R-1 and R-2; each accepted word shifts down the column at index C: row R-2 <= row R-1 <= in.
REQ-018 A 3-column shift register holds columns C-2..C of rows R-2..R; it shifts once per accepted word.
REQ-019 An accepted word with R>=2 and C>=2 produces a window one cycle later: win_valid=1, win = padded rows R-2..R by columns C-2..C, out_row=R-2, out_col=C-2.
REQ-020 Latency: accepted word to win_valid is exactly 1 cycle; each accepted word produces at most one window.
REQ-021 Each frame produces exactly (ROWS-2)*(COLS-2)=180 windows.
REQ-022 win, out_row and out_col hold their value while win_valid=0.
REQ-023 FSM states and transitions:
- IDLE to FILL on the first accepted word.
- FILL to STREAM when the word at (2,0) is accepted.
- STREAM to IDLE when the word at (ROWS-1,COLS-1) is accepted.
REQ-024 frame_done=1 in the same cycle as the win_valid for window (ROWS-3,COLS-3); frame_done=0 in all other cycles.
REQ-025 After (ROWS-1,COLS-1), the position wraps to (0,0); the next word starts a new frame with no sof required.
REQ-026 sof=1 in any state forces the position to (0,0) and the state to FILL. If in_valid=1 in the same cycle, that word is accepted as (0,0); otherwise the next accepted word is (0,0).
REQ-027 sof mid-frame abandons the old frame: no further windows and no frame_done for it; the line-buffer contents are don't-care because rows 0..1 of the new frame overwrite them before use.
REQ-028 The window pipeline register updates from the accepted word regardless of sof; win_valid obeys REQ-019 using the position after sof is applied.

Reset
REQ-029 rst=0 asynchronously clears R, C, the state (IDLE), win_valid, frame_done, busy, out_row, out_col and win to 0.
REQ-030 Line-buffer storage need not be reset.
REQ-031 Reset asserted mid-frame discards that frame; the first accepted word after release is (0,0).

Verification
REQ-032 Full frame, continuous in_valid, lane 0 of each word = 17R+C. The first win_valid arrives one cycle after word 36 (0-based). That window has out_row=0, out_col=0, top-left lane value 0, centre 18, bottom-right 36.
REQ-033 Same frame: count exactly 180 win_valid pulses. The last has out_row=11, out_col=14 and frame_done=1. After it, busy=0 and the state is IDLE.
REQ-034 Random in_valid gaps of 0..5 cycles: window contents and indices match REQ-032/033 exactly, and win_valid never asserts during a gap.
REQ-035 sof with in_valid=1 at padded row 5 mid-frame: no window until new (2,2) is accepted; that window's centre value = new word (1,1); no frame_done for the aborted frame.
REQ-036 Two back-to-back frames without sof: 360 windows and 2 frame_done pulses. The second frame's first window again has out_row=0, out_col=0.
REQ-037 rst pulsed low at padded row 7: win_valid, frame_done and busy are 0 immediately, before the next clock edge. After release, the next frame behaves per REQ-032.

Source files
------------

// File: rtl/window_gen_3x3_if.sv
// Bundles the padded pixel stream in and the 3x3 window stream out.
// No timing of its own; purely a port grouping.
// No backpressure: producer drives, consumer must take every window.
interface window_gen_3x3_if #(
  parameter int WL = 96
);
  logic            sof;
  logic            in_valid;
  logic [WL-1:0]   in;
  logic            win_valid;
  logic [9*WL-1:0] win;
  logic [3:0]      out_row;
  logic [3:0]      out_col;
  logic            frame_done;
  logic            busy;

  // Stream source / window sink side
  modport master (
    output sof, in_valid, in,
    input  win_valid, win, out_row, out_col, frame_done, busy
  );

  // Window generator side
  modport slave (
    input  sof, in_valid, in,
    output win_valid, win, out_row, out_col, frame_done, busy
  );
endinterface

// File: rtl/window_gen_3x3.sv
// Builds 3x3 windows from a padded raster stream using two line buffers.
// Latency: one cycle from an accepted word to its window.
// No backpressure: every accepted word is consumed; in_valid=0 freezes all state.
module window_gen_3x3 #(
  parameter int WL   = 96,
  parameter int COLS = 17,
  parameter int ROWS = 14
) (
  input  logic           clk,
  input  logic           rst,
  window_gen_3x3_if.slave bus
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   row_q, row_d, pos_row;
  logic [CW-1:0]   col_q, col_d, pos_col;
  logic            acc;
  logic            is_win;
  logic            is_last;

  // Line buffers: lb1 holds padded row R-1, lb2 holds row R-2, indexed by column
  logic [WL-1:0]   lb1 [COLS];
  logic [WL-1:0]   lb2 [COLS];

  // Column pipeline: col_a_q is column C-1, col_b_q is column C-2 (index 0 = top row)
  logic [WL-1:0]   col_a_q [3];
  logic [WL-1:0]   col_b_q [3];
  logic [WL-1:0]   cur_col [3];
  logic [9*WL-1:0] win_d;

  logic            win_valid_q;
  logic            frame_done_q;
  logic [3:0]      out_row_q;
  logic [3:0]      out_col_q;
  logic [9*WL-1:0] win_q;

  assign acc = bus.in_valid;

  // sof overrides the stored position, so a word arriving with sof is (0,0)
  assign pos_row = bus.sof ? '0 : row_q;
  assign pos_col = bus.sof ? '0 : col_q;

  assign is_win  = acc && (pos_row >= RW'(2)) && (pos_col >= CW'(2));
  assign is_last = (pos_row == RW'(ROWS - 1)) && (pos_col == CW'(COLS - 1));

  // Next padded position: raster advance on accept, wrap to (0,0) after the last word
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (bus.sof) begin
      row_d = '0;
      col_d = '0;
    end
    if (acc) begin
      if (pos_col == CW'(COLS - 1)) begin
        col_d = '0;
        row_d = (pos_row == RW'(ROWS - 1)) ? '0 : pos_row + RW'(1);
      end else begin
        col_d = pos_col + CW'(1);
        row_d = pos_row;
      end
    end
  end

  // Frame FSM next state: sof always restarts filling
  always_comb begin
    state_d = state_q;
    if (bus.sof) begin
      state_d = FILL;
    end else if (acc) begin
      case (state_q)
        IDLE:    state_d = FILL;
        FILL:    if (pos_row == RW'(2) && pos_col == '0) state_d = STREAM;
        STREAM:  if (is_last) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Current column as seen at the accepted word: rows R-2, R-1 from buffers, row R live
  always_comb begin
    cur_col[0] = lb2[pos_col];
    cur_col[1] = lb1[pos_col];
    cur_col[2] = bus.in;
  end

  // Assemble window: element (r,c) at WL*(3r+c), c=0 is the oldest column
  always_comb begin
    win_d = '0;
    for (int r = 0; r < 3; r++) begin
      win_d[WL*(3*r)   +: WL] = col_b_q[r];
      win_d[WL*(3*r+1) +: WL] = col_a_q[r];
      win_d[WL*(3*r+2) +: WL] = cur_col[r];
    end
  end

  // Storage shift on accept; contents are overwritten before use, so no reset
  always_ff @(posedge clk) begin
    if (acc) begin
      lb2[pos_col] <= lb1[pos_col];
      lb1[pos_col] <= bus.in;
      for (int r = 0; r < 3; r++) begin
        col_b_q[r] <= col_a_q[r];
        col_a_q[r] <= cur_col[r];
      end
    end
  end

  // Position and FSM state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q   <= '0;
      col_q   <= '0;
      state_q <= IDLE;
    end else begin
      row_q   <= row_d;
      col_q   <= col_d;
      state_q <= state_d;
    end
  end

  // Window output register; window data and indices hold between windows
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      win_q        <= '0;
    end else begin
      win_valid_q  <= is_win;
      frame_done_q <= is_win && is_last;
      if (is_win) begin
        out_row_q <= 4'(pos_row - RW'(2));
        out_col_q <= 4'(pos_col - CW'(2));
        win_q     <= win_d;
      end
    end
  end

  assign bus.win_valid  = win_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.out_row    = out_row_q;
  assign bus.out_col    = out_col_q;
  assign bus.win        = win_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_window_gen_3x3.sv
// Directed bench for window_gen_3x3: full frames, gaps, sof abort, back-to-back, reset.
// Expected windows come from a word pattern lane0=17R+C, lane1=~lane0, lane2=frame tag.
// Inputs change on the falling edge; outputs are sampled on the next falling edge.
module tb_window_gen_3x3;
  localparam int WL   = 96;
  localparam int COLS = 17;
  localparam int ROWS = 14;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  window_gen_3x3_if #(.WL(WL)) bus ();

  window_gen_3x3 #(.WL(WL), .COLS(COLS), .ROWS(ROWS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int vectors    = 0;
  int miscompares = 0;
  int exp_r = 0, exp_c = 0;
  int tag = 0;
  int win_cnt = 0, fd_cnt = 0;
  int words_in_frame = 0;
  bit seen_first = 0;
  logic [9*WL-1:0] held_win = '0;

  function automatic logic [WL-1:0] mk_word(input int t, input int r, input int c);
    logic [31:0] v;
    v = 32'(17 * r + c);
    return {32'(t), ~v, v};
  endfunction

  function automatic logic [9*WL-1:0] mk_win(input int t, input int r0, input int c0);
    logic [9*WL-1:0] w;
    w = '0;
    for (int rr = 0; rr < 3; rr++)
      for (int cc = 0; cc < 3; cc++)
        w[WL*(3*rr+cc) +: WL] = mk_word(t, r0 + rr, c0 + cc);
    return w;
  endfunction

  // One clock of stimulus followed by checks of what that clock produced
  task automatic step(input bit s, input bit v);
    logic [WL-1:0]   d;
    logic [9*WL-1:0] w;
    bit ev, efd;
    int er, ec;
    if (s) begin exp_r = 0; exp_c = 0; end
    if (v && exp_r == 0 && exp_c == 0) begin words_in_frame = 0; seen_first = 0; end
    d   = v ? mk_word(tag, exp_r, exp_c) : {$urandom(), $urandom(), $urandom()};
    ev  = v && exp_r >= 2 && exp_c >= 2;
    efd = v && exp_r == ROWS - 1 && exp_c == COLS - 1;
    er  = exp_r - 2;
    ec  = exp_c - 2;
    bus.sof = s; bus.in_valid = v; bus.in = d;
    if (v) begin
      words_in_frame++;
      if (exp_c == COLS - 1) begin
        exp_c = 0;
        exp_r = (exp_r == ROWS - 1) ? 0 : exp_r + 1;
      end else exp_c++;
    end
    @(negedge clk);
    bus.sof = 1'b0; bus.in_valid = 1'b0;
    if (bus.win_valid === 1'b1) win_cnt++;
    if (bus.frame_done === 1'b1) fd_cnt++;
    vectors++;
    if (bus.win_valid !== ev) begin
      miscompares++;
      $display("FAIL win_valid at t=%0t: got %b expected %b", $time, bus.win_valid, ev);
    end
    vectors++;
    if (bus.frame_done !== efd) begin
      miscompares++;
      $display("FAIL frame_done at t=%0t: got %b expected %b", $time, bus.frame_done, efd);
    end
    if (bus.win_valid === 1'b1 && !seen_first) begin
      seen_first = 1;
      vectors++;
      if (words_in_frame - 1 != 36) begin
        miscompares++;
        $display("FAIL first_window_word: got %0d expected 36", words_in_frame - 1);
      end
    end
    if (ev) begin
      held_win = mk_win(tag, er, ec);
      vectors++;
      if (bus.out_row !== 4'(er)) begin
        miscompares++;
        $display("FAIL out_row: got %0d expected %0d", bus.out_row, er);
      end
      vectors++;
      if (bus.out_col !== 4'(ec)) begin
        miscompares++;
        $display("FAIL out_col: got %0d expected %0d", bus.out_col, ec);
      end
      if (er == 0 && ec == 0) begin
        w = bus.win;
        vectors++;
        if (w[31:0] !== 32'd0 || w[4*WL +: 32] !== 32'd18 || w[8*WL +: 32] !== 32'd36 ||
            w[4*WL+64 +: 32] !== 32'(tag)) begin
          miscompares++;
          $display("FAIL first_window_lanes: got tl=%0d c=%0d br=%0d tag=%0d expected 0 18 36 %0d",
                   w[31:0], w[4*WL +: 32], w[8*WL +: 32], w[4*WL+64 +: 32], tag);
        end
      end
    end
    // Window must equal the latest expected one, both on new windows and while holding
    vectors++;
    if (bus.win !== held_win) begin
      miscompares++;
      $display("FAIL win_data at t=%0t: got %h expected %h", $time, bus.win[191:0], held_win[191:0]);
    end
  endtask

  task automatic check_counts(input string name, input int wins, input int fds);
    vectors++;
    if (win_cnt != wins) begin
      miscompares++;
      $display("FAIL %s window_count: got %0d expected %0d", name, win_cnt, wins);
    end
    vectors++;
    if (fd_cnt != fds) begin
      miscompares++;
      $display("FAIL %s frame_done_count: got %0d expected %0d", name, fd_cnt, fds);
    end
  endtask

  task automatic test_reset();
    bus.sof = 1'b0; bus.in_valid = 1'b0; bus.in = '0;
    rst = 1'b0;
    #12;
    vectors++;
    if (bus.win_valid !== 1'b0 || bus.frame_done !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got vld=%b fd=%b busy=%b expected 0 0 0",
               bus.win_valid, bus.frame_done, bus.busy);
    end
    vectors++;
    if (bus.out_row !== 4'd0 || bus.out_col !== 4'd0 || bus.win !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got row=%0d col=%0d expected 0 0 and zero win",
               bus.out_row, bus.out_col);
    end
    @(negedge clk);
    rst = 1'b1;
    exp_r = 0; exp_c = 0; held_win = '0;
    @(negedge clk);
  endtask

  task automatic test_full_frame();
    tag = 1; win_cnt = 0; fd_cnt = 0;
    for (int i = 0; i < ROWS * COLS; i++) begin
      step(1'b0, 1'b1);
      if (i == 0) begin
        vectors++;
        if (bus.busy !== 1'b1) begin
          miscompares++;
          $display("FAIL busy_after_first_word: got %b expected 1", bus.busy);
        end
      end
    end
    vectors++;
    if (bus.out_row !== 4'd11 || bus.out_col !== 4'd14 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL last_window: got row=%0d col=%0d busy=%b expected 11 14 0",
               bus.out_row, bus.out_col, bus.busy);
    end
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check_counts("full_frame", 180, 1);
  endtask

  task automatic test_gaps();
    tag = 7; win_cnt = 0; fd_cnt = 0;
    for (int i = 0; i < ROWS * COLS; i++) begin
      step(1'b0, 1'b1);
      repeat ($urandom_range(0, 5)) step(1'b0, 1'b0);
    end
    check_counts("gaps", 180, 1);
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL gaps_busy_end: got %b expected 0", bus.busy);
    end
  endtask

  task automatic test_sof_abort();
    tag = 2; win_cnt = 0; fd_cnt = 0;
    while (!(exp_r == 5 && exp_c == 4)) step(1'b0, 1'b1);
    win_cnt = 0;
    tag = 3;
    step(1'b1, 1'b1);
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL sof_busy: got %b expected 1", bus.busy);
    end
    for (int i = 1; i < ROWS * COLS; i++) step(1'b0, 1'b1);
    check_counts("sof_abort", 180, 1);
  endtask

  task automatic test_back_to_back();
    tag = 4; win_cnt = 0; fd_cnt = 0;
    for (int i = 0; i < 2 * ROWS * COLS; i++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check_counts("back_to_back", 360, 2);
  endtask

  task automatic test_reset_mid();
    tag = 5; win_cnt = 0; fd_cnt = 0;
    while (!(exp_r == 7 && exp_c == 5)) step(1'b0, 1'b1);
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (bus.win_valid !== 1'b0 || bus.frame_done !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got vld=%b fd=%b busy=%b expected 0 0 0",
               bus.win_valid, bus.frame_done, bus.busy);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    exp_r = 0; exp_c = 0; held_win = '0;
    tag = 6; win_cnt = 0; fd_cnt = 0;
    for (int i = 0; i < ROWS * COLS; i++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check_counts("reset_mid", 180, 1);
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_gaps();
    test_sof_abort();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
